// File: rtl/rr_stream_distributor.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_distributor
// Purpose  : Takes one valid/ready stream and sends each beat to exactly one
//            of NumOup output streams. The target is chosen either from
//            sel_i (ExtSel=1) or by an internal round-robin pointer, which
//            can skip outputs that are not ready (SkipBusy=1). Each beat is
//            held in a single registered output stage.
// Ports    : clk      - clock
//            rst_n    - asynchronous reset, active HIGH (despite the name)
//            flush_i  - synchronous reset of the round-robin pointer
//            sel_i    - external target index, used when ExtSel=1
//            valid_i  - input beat valid
//            ready_o  - input beat accepted when valid_i && ready_o
//            data_i   - input payload
//            valid_o  - per-output valid, one-hot or zero
//            ready_i  - per-output ready
//            data_o   - payload of the buffered beat, shared by all outputs
//            idx_o    - index of the output holding the buffered beat
// Revision : 1.0 - initial release
// ============================================================================
module rr_stream_distributor #(
    parameter int NumOup    = 7,
    parameter int DataWidth = 45,
    parameter bit ExtSel    = 1'b0,
    parameter bit SkipBusy  = 1'b1,
    parameter int IdxWidth  = (NumOup > 1) ? $clog2(NumOup) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic [IdxWidth-1:0]  sel_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic [NumOup-1:0]    valid_o,
    input  logic [NumOup-1:0]    ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [IdxWidth-1:0]  idx_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumOup - 1);
    localparam logic [IdxWidth:0]   NumOupW = (IdxWidth+1)'(NumOup);

    logic                 full_q, full_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [IdxWidth-1:0]  idx_q,  idx_d;
    logic [IdxWidth-1:0]  rr_q,   rr_d;

    logic                 sel_ready;
    logic                 out_hs;
    logic                 in_hs;
    logic [IdxWidth-1:0]  tgt;
    logic [IdxWidth:0]    cand;
    logic [IdxWidth-1:0]  rr_next;

    // sel_i is only meaningful for ExtSel=1; keeps lint quiet otherwise.
    logic unused_sel;
    assign unused_sel = ^sel_i;

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NumOup; k++) begin : g_valid
        assign valid_o[k] = full_q && (idx_q == IdxWidth'(k));
    end

    // Ready of the output currently holding the beat; the loop keeps every
    // index into ready_i constant, which is also safe for NumOup=1.
    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < NumOup; k++) begin
            if (idx_q == IdxWidth'(k)) begin
                sel_ready = ready_i[k];
            end
        end
    end

    assign out_hs  = full_q && sel_ready;
    assign ready_o = !full_q || out_hs;
    assign in_hs   = valid_i && ready_o;
    assign data_o  = data_q;
    assign idx_o   = idx_q;

    // ------------------------------------------------------------------
    // Target selection
    // ------------------------------------------------------------------
    always_comb begin
        tgt  = rr_q;
        cand = '0;
        if (ExtSel) begin
            // Out-of-range selects are clamped onto the last output.
            tgt = (sel_i > LastIdx) ? LastIdx : sel_i;
        end else if (SkipBusy) begin
            // Walk the cyclic order backwards so the last hit is the ready
            // output closest to rr_q; none ready leaves tgt at rr_q.
            for (int off = NumOup - 1; off >= 0; off--) begin
                cand = {1'b0, rr_q} + (IdxWidth+1)'(off);
                if (cand >= NumOupW) begin
                    cand = cand - NumOupW;
                end
                for (int k = 0; k < NumOup; k++) begin
                    if ((cand == (IdxWidth+1)'(k)) && ready_i[k]) begin
                        tgt = IdxWidth'(k);
                    end
                end
            end
        end
    end

    // Explicit wrap so non-power-of-two NumOup works.
    assign rr_next = (tgt == LastIdx) ? '0 : tgt + IdxWidth'(1);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        idx_d  = idx_q;
        rr_d   = rr_q;
        if (in_hs) begin
            // Also covers a same-cycle out_hs: the new beat replaces the old.
            full_d = 1'b1;
            data_d = data_i;
            idx_d  = tgt;
        end else if (out_hs) begin
            full_d = 1'b0;
        end
        if (flush_i) begin
            rr_d = '0;
        end else if (in_hs && !ExtSel) begin
            rr_d = rr_next;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            idx_q  <= '0;
            rr_q   <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            idx_q  <= idx_d;
            rr_q   <= rr_d;
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_onehot_valid : assert property (@(posedge clk) disable iff (rst_n)
        $onehot0(valid_o));

    a_stable_while_stalled : assert property (@(posedge clk) disable iff (rst_n)
        (full_q && !sel_ready) |=>
            ($stable(valid_o) && $stable(data_o) && $stable(idx_o)));

    a_ready_known : assert property (@(posedge clk) disable iff (rst_n)
        !$isunknown(ready_o));

    a_sel_in_range : assert property (@(posedge clk) disable iff (rst_n)
        (ExtSel && in_hs) |-> (sel_i <= LastIdx));

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_distributor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_stream_distributor
// Purpose  : Self-checking bench for rr_stream_distributor. One instance uses
//            round-robin with busy skipping, a second uses external select.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_stream_distributor;

    localparam int N  = 7;
    localparam int DW = 45;
    localparam int IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Round-robin instance
    logic          rr_flush, rr_valid, rr_ready_o;
    logic [IW-1:0] rr_sel;
    logic [DW-1:0] rr_data, rr_data_o;
    logic [N-1:0]  rr_valid_o, rr_rdy;
    logic [IW-1:0] rr_idx_o;

    // External-select instance
    logic          ex_flush, ex_valid, ex_ready_o;
    logic [IW-1:0] ex_sel;
    logic [DW-1:0] ex_data, ex_data_o;
    logic [N-1:0]  ex_valid_o, ex_rdy;
    logic [IW-1:0] ex_idx_o;

    rr_stream_distributor #(
        .NumOup(N), .DataWidth(DW), .ExtSel(1'b0), .SkipBusy(1'b1)
    ) dut_rr (
        .clk(clk), .rst_n(rst_n), .flush_i(rr_flush), .sel_i(rr_sel),
        .valid_i(rr_valid), .ready_o(rr_ready_o), .data_i(rr_data),
        .valid_o(rr_valid_o), .ready_i(rr_rdy), .data_o(rr_data_o),
        .idx_o(rr_idx_o)
    );

    rr_stream_distributor #(
        .NumOup(N), .DataWidth(DW), .ExtSel(1'b1), .SkipBusy(1'b1)
    ) dut_ex (
        .clk(clk), .rst_n(rst_n), .flush_i(ex_flush), .sel_i(ex_sel),
        .valid_i(ex_valid), .ready_o(ex_ready_o), .data_i(ex_data),
        .valid_o(ex_valid_o), .ready_i(ex_rdy), .data_o(ex_data_o),
        .idx_o(ex_idx_o)
    );

    int tot = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Apply round-robin inputs just after the falling edge; outputs are
    // sampled 1 ns later, well before the next rising edge.
    task automatic drv(input logic f, input logic v, input logic [DW-1:0] d,
                       input logic [N-1:0] r);
        @(negedge clk);
        rr_flush = f;
        rr_valid = v;
        rr_data  = d;
        rr_rdy   = r;
        #1;
    endtask

    typedef struct {
        logic          fl;
        logic          v;
        logic [DW-1:0] d;
        logic [N-1:0]  r;
        logic [N-1:0]  e_valid;
        logic [IW-1:0] e_idx;
        logic [DW-1:0] e_data;
        logic          e_ready;
    } vec_t;

    localparam logic [DW-1:0] D1 = 45'h0A1, D2 = 45'h0A2, D3 = 45'h0A3, D4 = 45'h0A4;
    localparam logic [DW-1:0] D5 = 45'h0A5, D6 = 45'h0A6, D7 = 45'h0A7;
    localparam logic [DW-1:0] Z  = 45'h0;

    vec_t vt [16];

    logic [DW-1:0] sbq [N][$];
    int            cnt [N];

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc, cyc;
        bit          full_m, exp_rdy, o_hs;
        int          idx_m;
        logic [DW-1:0] popped;

        // Expected outputs are those seen with the row's inputs applied,
        // before the clock edge that ends the row.
        vt[0]  = '{1'b0, 1'b0, Z,  7'h7F, 7'h00, 3'd0, Z,  1'b1};
        vt[1]  = '{1'b0, 1'b1, D1, 7'h7F, 7'h00, 3'd0, Z,  1'b1};
        vt[2]  = '{1'b0, 1'b1, D2, 7'h7F, 7'h01, 3'd0, D1, 1'b1};
        vt[3]  = '{1'b0, 1'b1, D3, 7'h13, 7'h02, 3'd1, D2, 1'b1}; // rr=2 skips to 4
        vt[4]  = '{1'b0, 1'b1, D4, 7'h00, 7'h10, 3'd4, D3, 1'b0};
        vt[5]  = '{1'b0, 1'b1, D4, 7'h10, 7'h10, 3'd4, D3, 1'b1}; // rr=5, only 4 ready
        vt[6]  = '{1'b0, 1'b0, Z,  7'h10, 7'h10, 3'd4, D4, 1'b1};
        vt[7]  = '{1'b0, 1'b1, D5, 7'h00, 7'h00, 3'd4, D4, 1'b1}; // none ready -> 5
        vt[8]  = '{1'b0, 1'b0, Z,  7'h00, 7'h20, 3'd5, D5, 1'b0};
        vt[9]  = '{1'b0, 1'b0, Z,  7'h00, 7'h20, 3'd5, D5, 1'b0};
        vt[10] = '{1'b0, 1'b0, Z,  7'h20, 7'h20, 3'd5, D5, 1'b1};
        vt[11] = '{1'b0, 1'b0, Z,  7'h00, 7'h00, 3'd5, D5, 1'b1};
        vt[12] = '{1'b1, 1'b1, D6, 7'h01, 7'h00, 3'd5, D5, 1'b1}; // rr=6 -> 0, flush keeps rr 0
        vt[13] = '{1'b0, 1'b1, D7, 7'h7F, 7'h01, 3'd0, D6, 1'b1};
        vt[14] = '{1'b0, 1'b0, Z,  7'h7F, 7'h01, 3'd0, D7, 1'b1};
        vt[15] = '{1'b0, 1'b0, Z,  7'h00, 7'h00, 3'd0, D7, 1'b1};

        rst_n    = 1'b1;
        rr_flush = 1'b0; rr_sel = '0; rr_valid = 1'b0; rr_data = '0; rr_rdy = '0;
        ex_flush = 1'b0; ex_sel = '0; ex_valid = 1'b0; ex_data = '0; ex_rdy = '0;
        full_m   = 1'b0;
        idx_m    = 0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        drv(1'b0, 1'b1, D7, 7'h7F);
        chk("rst_valid", rr_valid_o, 0);
        chk("rst_data",  rr_data_o, 0);
        chk("rst_idx",   rr_idx_o, 0);
        chk("rst_ready", rr_ready_o, 1);
        chk("rst_ex_ready", ex_ready_o, 1);
        rr_valid = 1'b0;
        rst_n    = 1'b0;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 16; i++) begin
            drv(vt[i].fl, vt[i].v, vt[i].d, vt[i].r);
            chk($sformatf("vec%0d_valid", i), rr_valid_o, vt[i].e_valid);
            chk($sformatf("vec%0d_idx",   i), rr_idx_o,   vt[i].e_idx);
            chk($sformatf("vec%0d_data",  i), rr_data_o,  vt[i].e_data);
            chk($sformatf("vec%0d_ready", i), rr_ready_o, vt[i].e_ready);
        end

        // ---------------- backpressure + flush during stall ----------------
        // rr=1, empty on entry
        drv(1'b0, 1'b1, 45'h0E1, 7'h7F);                 // -> 1
        drv(1'b0, 1'b1, 45'h0E2, 7'h7F);                 // -> 2
        drv(1'b0, 1'b0, Z, 7'h7F);                       // drain, rr=3
        drv(1'b0, 1'b1, 45'h0E3, 7'h00);                 // none ready -> 3, rr=4
        chk("stall_load_ready", rr_ready_o, 1);
        for (int i = 0; i < 20; i++) begin
            drv((i == 7), 1'b1, 45'h100 + DW'(i), 7'h00);
            chk($sformatf("stall%0d_valid", i), rr_valid_o, 7'h08);
            chk($sformatf("stall%0d_idx", i),   rr_idx_o, 3);
            chk($sformatf("stall%0d_data", i),  rr_data_o, 45'h0E3);
            chk($sformatf("stall%0d_ready", i), rr_ready_o, 0);
        end
        drv(1'b0, 1'b1, 45'h0E5, 7'h7F);                 // E3 out, E5 in -> 0 after flush
        chk("release_valid", rr_valid_o, 7'h08);
        chk("release_ready", rr_ready_o, 1);
        drv(1'b0, 1'b0, Z, 7'h00);
        chk("postflush_valid", rr_valid_o, 7'h01);
        chk("postflush_data",  rr_data_o, 45'h0E5);
        chk("postflush_ready", rr_ready_o, 0);
        drv(1'b0, 1'b0, Z, 7'h01);
        drv(1'b0, 1'b0, Z, 7'h00);
        chk("drained_valid", rr_valid_o, 0);

        // ---------------- reset mid-stream ----------------
        // rr=1, empty
        drv(1'b0, 1'b1, 45'h0F1, 7'h00);                 // -> 1
        drv(1'b0, 1'b0, Z, 7'h00);
        chk("pre_rst_valid", rr_valid_o, 7'h02);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", rr_valid_o, 0);
        chk("mid_rst_ready", rr_ready_o, 1);
        chk("mid_rst_data",  rr_data_o, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drv(1'b0, 1'b1, 45'h0F2, 7'h00);                 // rr back at 0 -> 0
        chk("post_rst_ready", rr_ready_o, 1);
        drv(1'b0, 1'b0, Z, 7'h7F);
        chk("post_rst_valid", rr_valid_o, 7'h01);
        chk("post_rst_idx",   rr_idx_o, 0);
        chk("post_rst_data",  rr_data_o, 45'h0F2);

        // ---------------- 70-beat round-robin stream ----------------
        drv(1'b1, 1'b0, Z, 7'h7F);                       // rr=0
        for (int k = 0; k < N; k++) cnt[k] = 0;
        for (int c = 0; c <= 70; c++) begin
            drv(1'b0, (c < 70), 45'h1000 + DW'(c), 7'h7F);
            chk($sformatf("strm%0d_ready", c), rr_ready_o, 1);
            if (c == 0) begin
                chk("strm0_valid", rr_valid_o, 0);
            end else begin
                chk($sformatf("strm%0d_valid", c), rr_valid_o, 7'h01 << ((c - 1) % N));
                chk($sformatf("strm%0d_data", c),  rr_data_o, 45'h1000 + DW'(c - 1));
                for (int k = 0; k < N; k++) if (rr_valid_o[k]) cnt[k]++;
            end
        end
        for (int k = 0; k < N; k++) chk($sformatf("strm_cnt%0d", k), cnt[k], 10);
        drv(1'b0, 1'b0, Z, 7'h7F);
        chk("strm_end_valid", rr_valid_o, 0);

        // ---------------- external select, random traffic ----------------
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            @(negedge clk);
            ex_valid = ($urandom_range(0, 9) < 7);
            ex_sel   = IW'($urandom_range(0, N - 1));
            ex_data  = DW'({$urandom, $urandom});
            ex_rdy   = N'($urandom);
            #1;
            o_hs    = full_m && ex_rdy[idx_m];
            exp_rdy = !full_m || o_hs;
            chk("ext_valid", ex_valid_o, full_m ? (7'h01 << idx_m) : 7'h00);
            chk("ext_ready", ex_ready_o, exp_rdy);
            if (o_hs) begin
                chk("ext_idx", ex_idx_o, idx_m);
                if (sbq[idx_m].size() == 0) begin
                    chk("ext_sb_empty", 1, 0);
                end else begin
                    popped = sbq[idx_m].pop_front();
                    chk("ext_data", ex_data_o, popped);
                end
                full_m = 1'b0;
            end
            if (ex_valid && exp_rdy) begin
                sbq[ex_sel].push_back(ex_data);
                full_m = 1'b1;
                idx_m  = int'(ex_sel);
                acc++;
            end
            cyc++;
        end
        chk("ext_beats", acc, 10000);
        @(negedge clk);
        ex_valid = 1'b0;
        ex_rdy   = '1;
        #1;
        if (full_m) begin
            chk("ext_last_idx", ex_idx_o, idx_m);
            popped = (sbq[idx_m].size() != 0) ? sbq[idx_m].pop_front() : '0;
            chk("ext_last_data", ex_data_o, popped);
        end
        @(negedge clk);
        #1;
        chk("ext_final_valid", ex_valid_o, 0);
        for (int k = 0; k < N; k++) chk($sformatf("ext_leftover%0d", k), sbq[k].size(), 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_stream_distributor.md
Name: rr_stream_distributor

Overview:
- One-to-many counterpart of the round-robin arbitration tree: takes one valid/ready stream and hands each beat to one of NumOup output streams.
- Target selection is either round-robin or external (sel_i); `idx_o` reports which output holds the beat.
- One registered output stage; sits wherever arbitrated traffic is spread back out, e.g. a work dispatcher feeding parallel units.

Parameters:
- NumOup, 7, number of output streams (≥1).
- DataWidth, 45, payload width in bits.
- ExtSel, 0, 1: target taken from sel_i; 0: internal round-robin.
- SkipBusy, 1, round-robin only: prefer the next output whose ready_i is currently high.
- IdxWidth, (NumOup>1)?$clog2(NumOup):1, derived; width of indices.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous round-robin pointer reset
- sel_i  in  IdxWidth  target output when ExtSel=1; sampled with the input handshake
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- data_i  in  DataWidth  input payload
- valid_o  out  NumOup  per-output valid, at most one bit set (one-hot or zero)
- ready_i  in  NumOup  per-output ready
- data_o  out  DataWidth  payload of the buffered beat, shared by all outputs
- idx_o  out  IdxWidth  index of the output holding the buffered beat

Behaviour:
- Reset (rst_n=1): full_q=0, data_q=0, idx_q=0, rr_q=0. Outputs during reset: valid_o=0, data_o=0, idx_o=0, ready_o=1.
- Buffer:
  - valid_o[idx_q] = full_q; all other valid_o bits are 0. data_o = data_q; idx_o = idx_q.
  - out_hs = full_q && ready_i[idx_q].
  - ready_o = !full_q || out_hs (combinational pass-through; no bubble on a back-to-back handshake).
- Load on in_hs = valid_i && ready_o: data_q <= data_i, idx_q <= tgt, full_q <= 1.
- On out_hs without in_hs: full_q <= 0; data_q and idx_q hold their values.
- Latency: exactly 1 cycle from input handshake to valid_o. Sustained throughput is 1 beat/cycle while the targeted outputs are ready.
- AXI stability: once valid_o[k] rises, valid_o[k], data_o and idx_o stay stable until ready_i[k]. No retargeting or withdrawal, including on flush.
- Target selection (tgt):
  - ExtSel=1: tgt = sel_i. sel_i ≥ NumOup is illegal; an assertion fires and the beat is routed to NumOup-1.
  - ExtSel=0, SkipBusy=0: tgt = rr_q.
  - ExtSel=0, SkipBusy=1: tgt = first index k in the cyclic order rr_q, rr_q+1, …, NumOup-1, 0, …, rr_q-1 with ready_i[k]=1. If none is ready, tgt = rr_q.
- Round-robin pointer:
  - On in_hs with ExtSel=0: rr_q <= (tgt == NumOup-1) ? 0 : tgt+1. Wrap is explicit; NumOup need not be a power of two.
  - rr_q never changes without in_hs, except on flush.
- flush_i: rr_q <= 0. It has priority over a same-cycle rr update; a same-cycle in_hs still loads, using the tgt computed from the old rr_q. The buffered beat is unaffected.
- Simultaneous in_hs and out_hs: the new beat replaces the old; full_q stays 1.
- NumOup=1: idx_o=0, rr_q stays 0; the block degenerates to a single-stage spill register.
- Reset mid-transfer: the buffered beat is dropped; valid_o drops asynchronously.
- Assertions:
  - $onehot0(valid_o).
  - Output stability while valid && !ready.
  - No X on ready_o after reset.

Test Plan:
- Round-robin, all ready (ExtSel=0, NumOup=7): valid_i=1 for 70 cycles, ready_i='1 → targets 0,1,…,6,0,… in order; each output gets 10 beats; one beat per cycle after a 1-cycle fill; data matches in order.
- SkipBusy: rr_q=2, ready_i=7'b0010011 → beat goes to output 4, rr_q becomes 5. Next cycle ready_i=0 → beat targets 5 and valid_o[5] holds until ready_i[5] rises.
- Backpressure stability: targeted ready_i low for 20 cycles → valid_o, data_o and idx_o remain constant and ready_o=0; one handshake follows when ready_i rises; no beat is lost or duplicated.
- ExtSel=1: random sel_i over 10000 beats with random ready_i → per-output scoreboard queues match data_o in order; 0 mismatches.
- Flush during stall: buffered beat to output 3, flush_i pulse → beat still delivered to 3; next round-robin target is 0 (or the first ready output from 0).
- Reset mid-stream: assert rst_n while full_q=1 → valid_o=0 and ready_o=1 immediately. After release, rr_q=0 and the first beat goes to output 0.
